// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that serialises per-requester I2C transactions onto one controller.
// Optional WAIT watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 7,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]               req_rw,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_REQ-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [$clog2(NUM_REQ)-1:0]       grant_id,
    output logic                             ctrl_start,
    output logic [ADDRESS_WIDTH-1:0]         ctrl_addr,
    output logic                             ctrl_rw,
    output logic [DATA_WIDTH-1:0]            ctrl_wdata,
    input  logic                             ctrl_done,
    input  logic                             ctrl_nack,
    input  logic [DATA_WIDTH-1:0]            ctrl_rdata,
    output logic                             ctrl_abort,
    output logic [1:0]                       dbg_state
);

    localparam int ID_W = $clog2(NUM_REQ);

    // Handshake: a requester holds req_valid with stable addr/rw/wdata; the request is
    // taken on the rising edge where req_ready (only ever in IDLE, one-hot) is high.
    // rsp_valid is a one-cycle strobe to the owner; rsp_err/rsp_rdata are valid with it.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    state_e                    state_q;
    logic [ID_W-1:0]           last_grant_q;
    logic [ID_W-1:0]           grant_q;
    logic [ADDRESS_WIDTH-1:0]  addr_q;
    logic                      rw_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      start_q;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic                      rsp_err_q;
    logic [DATA_WIDTH-1:0]     rsp_rdata_q;

    logic                      win_found;
    logic [ID_W-1:0]           win_idx;

    // Search begins one past the previous owner so every requester gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            logic [ID_W-1:0] cand;
            cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == S_IDLE) && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             abort_q;
    assign ctrl_abort = abort_q;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign ctrl_abort     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            grant_q      <= '0;
            addr_q       <= '0;
            rw_q         <= 1'b0;
            wdata_q      <= '0;
            start_q      <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            abort_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found) begin
                        addr_q       <= req_addr[win_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        rw_q         <= req_rw[win_idx];
                        wdata_q      <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
                        grant_q      <= win_idx;
                        last_grant_q <= win_idx;
                        start_q      <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= S_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still completes normally.
                    if (ctrl_done) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= ctrl_nack;
                        rsp_rdata_q          <= (rw_q && !ctrl_nack) ? ctrl_rdata : '0;
                        state_q              <= S_RESP;
                    end
`ifdef I2C_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_err_q            <= 1'b1;
                        rsp_rdata_q          <= '0;
                        abort_q              <= 1'b1;
                        state_q              <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rsp_valid_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
                    abort_q     <= 1'b0;
`endif
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign grant_id   = grant_q;
    assign ctrl_start = start_q;
    assign ctrl_addr  = addr_q;
    assign ctrl_rw    = rw_q;
    assign ctrl_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: round-robin order, read/write/NACK responses,
// timeout (when I2C_ARB_TIMEOUT_EN is defined) and reset during an open transaction.
module tb_i2c_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int AW = 7;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*AW-1:0] req_addr;
    logic [NR-1:0]   req_rw;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [1:0]      grant_id;
    logic            ctrl_start;
    logic [AW-1:0]   ctrl_addr;
    logic            ctrl_rw;
    logic [DW-1:0]   ctrl_wdata;
    logic            ctrl_done;
    logic            ctrl_nack;
    logic [DW-1:0]   ctrl_rdata;
    logic            ctrl_abort;
    logic [1:0]      dbg_state;

    logic [AW-1:0] addr_tbl  [4] = '{7'h10, 7'h11, 7'h12, 7'h13};
    logic          rw_tbl    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [DW-1:0] wdata_tbl [4] = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};

    int n_cmp = 0;
    int n_err = 0;

    i2c_req_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_rw(req_rw), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .grant_id(grant_id),
        .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr), .ctrl_rw(ctrl_rw),
        .ctrl_wdata(ctrl_wdata), .ctrl_done(ctrl_done), .ctrl_nack(ctrl_nack),
        .ctrl_rdata(ctrl_rdata), .ctrl_abort(ctrl_abort), .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs_a"}, 32'({rsp_valid, rsp_rdata, rsp_err, grant_id, ctrl_start}), 0);
        check({tag, "_outs_b"}, 32'({ctrl_addr, ctrl_rw, ctrl_wdata, ctrl_abort, req_ready}), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // Entered in an IDLE cycle with req_valid already driven; returns in the following IDLE cycle.
    task automatic run_txn(input int g, input logic [DW-1:0] rd, input logic nk, input int extra_wait,
                           input logic drop_after_accept, input logic done_early,
                           input logic [DW-1:0] exp_rd);
        logic [1:0] gi;
        gi = 2'(g);
        #1;
        check("accept_ready", 32'(req_ready), 32'd1 << g);
        step();
        check("issue_start", 32'(ctrl_start), 1);
        check("issue_grant", 32'(grant_id), g);
        check("issue_addr", 32'(ctrl_addr), 32'(addr_tbl[gi]));
        check("issue_rw", 32'(ctrl_rw), 32'(rw_tbl[gi]));
        check("issue_wdata", 32'(ctrl_wdata), 32'(wdata_tbl[gi]));
        check("issue_ready", 32'(req_ready), 0);
        if (drop_after_accept) req_valid[gi] = 1'b0;
        if (done_early) begin
            ctrl_done  = 1'b1;
            ctrl_nack  = 1'b1;
            ctrl_rdata = 8'hEE;
        end
        step();
        ctrl_done = 1'b0;
        ctrl_nack = 1'b0;
        check("wait_start", 32'(ctrl_start), 0);
        check("wait_state", 32'(dbg_state), 2);
        check("wait_rsp", 32'(rsp_valid), 0);
        for (int i = 0; i < extra_wait; i++) begin
            step();
            check("wait_hold_rsp", 32'(rsp_valid), 0);
            check("wait_hold_addr", 32'(ctrl_addr), 32'(addr_tbl[gi]));
        end
        ctrl_done  = 1'b1;
        ctrl_rdata = rd;
        ctrl_nack  = nk;
        step();
        ctrl_done  = 1'b0;
        ctrl_nack  = 1'b0;
        ctrl_rdata = '0;
        check("resp_valid", 32'(rsp_valid), 32'd1 << g);
        check("resp_err", 32'(rsp_err), 32'(nk));
        check("resp_rdata", 32'(rsp_rdata), 32'(exp_rd));
        check("resp_abort", 32'(ctrl_abort), 0);
        step();
        check("post_rsp_clear", 32'(rsp_valid), 0);
        check("post_state", 32'(dbg_state), 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_addr   = {7'h13, 7'h12, 7'h11, 7'h10};
        req_rw     = 4'b0101;
        req_wdata  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        ctrl_done  = 1'b0;
        ctrl_nack  = 1'b0;
        ctrl_rdata = '0;
        repeat (3) step();
        check_all_zero("reset");
        req_valid = '0;
        rst_n     = 1'b1;
        step();

        // 0110 from reset: requester 1 then 2
        req_valid = 4'b0110;
        run_txn(1, 8'h11, 1'b0, 0, 1'b0, 1'b0, 8'h00);
        run_txn(2, 8'h22, 1'b0, 0, 1'b0, 1'b0, 8'h22);
        req_valid = '0;
        step();
        check("idle_no_start", 32'(ctrl_start), 0);
        check("idle_state", 32'(dbg_state), 0);

        // all four valid from reset: 0,1,2,3,0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_valid = 4'b1111;
        run_txn(0, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 8'hA5);
        run_txn(1, 8'h5A, 1'b1, 1, 1'b0, 1'b0, 8'h00);
        run_txn(2, 8'h77, 1'b1, 0, 1'b0, 1'b1, 8'h00);
        run_txn(3, 8'h99, 1'b0, 2, 1'b1, 1'b0, 8'h00);
        run_txn(0, 8'h3C, 1'b0, 3, 1'b0, 1'b0, 8'h3C);
        req_valid = '0;
        step();

        // owner drops after accept, another request appears and withdraws while busy
        req_valid = 4'b0010;
        step();
        check("wd_issue_grant", 32'(grant_id), 1);
        req_valid = 4'b1000;
        step();
        req_valid  = '0;
        ctrl_done  = 1'b1;
        ctrl_rdata = 8'h66;
        step();
        ctrl_done  = 1'b0;
        ctrl_rdata = '0;
        check("wd_rsp_valid", 32'(rsp_valid), 32'b0010);
        check("wd_rsp_rdata", 32'(rsp_rdata), 0);
        step();
        check("wd_idle_ready", 32'(req_ready), 0);
        step();
        check("wd_no_start", 32'(ctrl_start), 0);
        check("wd_state", 32'(dbg_state), 0);
        check("wd_grant_kept", 32'(grant_id), 1);

        // WAIT with no done for TIMEOUT_CYCLES cycles
        req_valid = 4'b0100;
        step();
        check("to_grant", 32'(grant_id), 2);
        req_valid = '0;
        step();
        for (int i = 0; i < TO - 1; i++) begin
            step();
            check("to_wait_rsp", 32'(rsp_valid), 0);
            check("to_wait_abort", 32'(ctrl_abort), 0);
        end
        step();
`ifdef I2C_ARB_TIMEOUT_EN
        check("to_abort", 32'(ctrl_abort), 1);
        check("to_rsp_valid", 32'(rsp_valid), 32'b0100);
        check("to_rsp_err", 32'(rsp_err), 1);
        check("to_rsp_rdata", 32'(rsp_rdata), 0);
        step();
        check("to_abort_clear", 32'(ctrl_abort), 0);
        check("to_rsp_clear", 32'(rsp_valid), 0);
        check("to_state", 32'(dbg_state), 0);
`else
        check("nto_abort", 32'(ctrl_abort), 0);
        check("nto_rsp_valid", 32'(rsp_valid), 0);
        check("nto_state", 32'(dbg_state), 2);
        ctrl_done  = 1'b1;
        ctrl_rdata = 8'h5E;
        step();
        ctrl_done  = 1'b0;
        ctrl_rdata = '0;
        check("nto_rsp_valid_done", 32'(rsp_valid), 32'b0100);
        check("nto_rsp_err", 32'(rsp_err), 0);
        check("nto_rsp_rdata", 32'(rsp_rdata), 32'h5E);
        step();
`endif

        // reset while in WAIT, with a done arriving on the reset edge
        req_valid = 4'b1000;
        step();
        check("rw_grant", 32'(grant_id), 3);
        req_valid = '0;
        step();
        check("rw_in_wait", 32'(dbg_state), 2);
        rst_n      = 1'b0;
        ctrl_done  = 1'b1;
        ctrl_rdata = 8'hFF;
        step();
        ctrl_done  = 1'b0;
        ctrl_rdata = '0;
        check_all_zero("rw_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rw_no_rsp", 32'(rsp_valid), 0);
            check("rw_no_abort", 32'(ctrl_abort), 0);
        end
        req_valid = 4'b1111;
        run_txn(0, 8'h42, 1'b0, 0, 1'b0, 1'b0, 8'h42);
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, transfer byte width.
REQ-003 SHALL have parameter ADDRESS_WIDTH, default 7, target address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state cycle limit.
REQ-005 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port req_valid  in  NUM_REQ  per-requester transaction request.
REQ-008 SHALL have port req_ready  out  NUM_REQ  per-requester accept strobe.
REQ-009 SHALL have port req_addr  in  NUM_REQ*ADDRESS_WIDTH  packed target addresses, requester i at slice i.
REQ-010 SHALL have port req_rw  in  NUM_REQ  direction, 1=read, 0=write.
REQ-011 SHALL have port req_wdata  in  NUM_REQ*DATA_WIDTH  packed write bytes.
REQ-012 SHALL have port rsp_valid  out  NUM_REQ  one-cycle completion strobe to owner.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read byte, shared.
REQ-014 SHALL have port rsp_err  out  1  NACK or timeout, valid with rsp_valid.
REQ-015 SHALL have port grant_id  out  $clog2(NUM_REQ)  current/last owner index.
REQ-016 SHALL have ports ctrl_start out 1, ctrl_addr out ADDRESS_WIDTH, ctrl_rw out 1, ctrl_wdata out DATA_WIDTH toward the I2C controller.
REQ-017 SHALL have ports ctrl_done in 1, ctrl_nack in 1, ctrl_rdata in DATA_WIDTH, ctrl_abort out 1.

Function
REQ-018 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-019 IDLE: when any req_valid, SHALL assert req_ready for exactly one winner combinationally, latch its addr/rw/wdata, set grant_id, move to ISSUE.
REQ-020 Winner SHALL be chosen round-robin: search starts at (last_grant+1) mod NUM_REQ, wraps past NUM_REQ-1 to 0.
REQ-021 last_grant SHALL update on the accept edge only.
REQ-022 ISSUE: ctrl_start SHALL pulse high exactly one cycle; ctrl_addr/rw/wdata SHALL hold latched values from ISSUE through WAIT.
REQ-023 WAIT: on ctrl_done=1, SHALL latch ctrl_rdata and ctrl_nack and move to RESP.
REQ-024 ctrl_done outside WAIT SHALL be ignored.
REQ-025 RESP: rsp_valid[grant_id] SHALL be high exactly one cycle; rsp_err=latched nack; rsp_rdata=latched data for reads, 0 for writes or err=1.
REQ-026 Latency: req_ready edge N -> ctrl_start cycle N+1; ctrl_done at edge M -> rsp_valid cycle M+1.
REQ-027 No new request SHALL be accepted outside IDLE; req_valid withdrawn before acceptance SHALL be dropped without effect.
REQ-028 Requester deasserting req_valid after acceptance SHALL NOT affect the in-flight transaction.
REQ-029 Back-to-back: IDLE after RESP SHALL accept in the next cycle (minimum 4 cycles between accepts with 1-cycle done).

Reset
REQ-030 rst_n=0 at clock edge SHALL force IDLE, last_grant=NUM_REQ-1 (requester 0 highest priority), all outputs 0, latched fields 0.
REQ-031 Reset mid-transaction SHALL abandon it silently: no rsp_valid, no ctrl_abort.

Configuration
REQ-032 Macro I2C_ARB_TIMEOUT_EN defined: WAIT cycle counter; on reaching TIMEOUT_CYCLES without ctrl_done, ctrl_abort SHALL pulse one cycle, FSM to RESP with rsp_err=1, rsp_rdata=0; ctrl_done in that same cycle wins (normal completion).
REQ-033 Macro undefined: no counter, WAIT indefinite, ctrl_abort tied 0; port list unchanged.

Verification
REQ-034 req_valid=4'b0110 from reset -> grant 1 first, then 2; rsp_valid[1] then rsp_valid[2].
REQ-035 All four valid continuously -> grants 0,1,2,3,0 in order.
REQ-036 Read addr 7'h10, ctrl_done with ctrl_rdata=8'hA5, nack=0 -> rsp_rdata=8'hA5, rsp_err=0, one cycle after done.
REQ-037 Write with ctrl_done+ctrl_nack=1 -> rsp_err=1, rsp_rdata=8'h00.
REQ-038 I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ctrl_done -> ctrl_abort pulse after 16 WAIT cycles, rsp_err=1.
REQ-039 rst_n low during WAIT -> next cycle IDLE, all outputs 0, no rsp_valid.
